// File: rtl/deparser_layer_if.sv
// deparser_layer_if: configuration bus and header stream of one deparser layer.
// The slave modport is the layer's own view; master is the driving side.
interface deparser_layer_if #(
   parameter int HEAD_WIDTH = 1024,
   parameter int META_WIDTH = 512,
   parameter int RULE_NUM   = 8
);
   localparam int RIDX_W = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;

   logic                  i_rule_wren;
   logic                  i_rule_rden;
   logic [31:0]           i_rule_addr;
   logic [31:0]           i_rule_wdata;
   logic                  o_rule_rdata_valid;
   logic [31:0]           o_rule_rdata;
   logic                  i_head_valid;
   logic                  o_head_ready;
   logic [HEAD_WIDTH-1:0] i_head;
   logic [META_WIDTH-1:0] i_meta;
   logic                  o_head_valid;
   logic                  i_head_ready;
   logic [HEAD_WIDTH-1:0] o_head;
   logic                  o_hit;
   logic [RIDX_W-1:0]     o_rule_idx;

   modport slave (
      input  i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata,
      input  i_head_valid, i_head, i_meta, i_head_ready,
      output o_rule_rdata_valid, o_rule_rdata,
      output o_head_ready, o_head_valid, o_head, o_hit, o_rule_idx
   );

   modport master (
      output i_rule_wren, i_rule_rden, i_rule_addr, i_rule_wdata,
      output i_head_valid, i_head, i_meta, i_head_ready,
      input  o_rule_rdata_valid, o_rule_rdata,
      input  o_head_ready, o_head_valid, o_head, o_hit, o_rule_idx
   );
endinterface

// File: rtl/deparser_layer.sv
// deparser_layer: one protocol layer of the deparser pipeline. Extracts the
// layer type word, matches it against the type-rule table and writes the
// metadata key fields back into the header at the matched rule's offsets.
// Optional feature macro: DEPARSER_STATS_EN (hit/miss counters, config region 0x2).
module deparser_layer #(
   parameter int HEAD_WIDTH        = 1024,
   parameter int META_WIDTH        = 512,
   parameter int TYPE_WIDTH        = 16,
   parameter int TYPE_OFFSET_WIDTH = 6,
   parameter int KEY_FIELD_NUM     = 4,
   parameter int KEY_FIELD_WIDTH   = 16,
   parameter int KEY_OFFSET_WIDTH  = 6,
   parameter int RULE_NUM          = 8
) (
   input logic             i_clk,
   input logic             i_rst,
   deparser_layer_if.slave bus
);
   localparam int W      = KEY_FIELD_WIDTH;
   localparam int KEYS_W = KEY_FIELD_NUM * W;
   localparam int RIDX_W = (RULE_NUM > 1) ? $clog2(RULE_NUM) : 1;
   localparam logic [HEAD_WIDTH-1:0] FIELD_TOP = {{W{1'b1}}, {(HEAD_WIDTH-W){1'b0}}};

   // rule table and type offset
   logic [TYPE_OFFSET_WIDTH-1:0] type_offset;
   logic                         rule_valid [RULE_NUM];
   logic [TYPE_WIDTH-1:0]        rule_data  [RULE_NUM];
   logic [TYPE_WIDTH-1:0]        rule_mask  [RULE_NUM];
   logic                         key_en     [RULE_NUM][KEY_FIELD_NUM];
   logic [KEY_OFFSET_WIDTH-1:0]  key_off    [RULE_NUM][KEY_FIELD_NUM];

   // config address decode
   logic [3:0]        region;
   logic [3:0]        word;
   logic [7:0]        rule_sel_raw;
   logic              rule_addr_ok;
   logic [RIDX_W-1:0] rule_sel;
   logic [31:0]       rd_mux;

   assign region       = bus.i_rule_addr[31:28];
   assign word         = bus.i_rule_addr[3:0];
   assign rule_sel_raw = bus.i_rule_addr[11:4];
   assign rule_addr_ok = ({24'd0, rule_sel_raw} < 32'(RULE_NUM));
   assign rule_sel     = rule_sel_raw[RIDX_W-1:0];

   // pipeline state
   logic                  stall;
   logic [HEAD_WIDTH-1:0] s1_head;
   logic [KEYS_W-1:0]     s1_keys;
   logic [TYPE_WIDTH-1:0] s1_type;
   logic                  s1_valid;
   logic [TYPE_WIDTH-1:0] in_type;
   int                    type_shamt;
   logic                  match_hit;
   logic [RIDX_W-1:0]     match_idx;
   logic [HEAD_WIDTH-1:0] new_head;

   logic unused_bits;
   assign unused_bits = ^{bus.i_rule_wdata[31:16], bus.i_rule_addr[27:12],
                          bus.i_meta[META_WIDTH-KEYS_W-1:0]};

   assign stall            = bus.o_head_valid & ~bus.i_head_ready;
   assign bus.o_head_ready = ~stall;

   // Rule table and type offset writes; unmapped addresses are ignored.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         type_offset <= '0;
         for (int r = 0; r < RULE_NUM; r++) begin
            rule_valid[r] <= 1'b0;
            rule_data[r]  <= '0;
            rule_mask[r]  <= '0;
            for (int j = 0; j < KEY_FIELD_NUM; j++) begin
               key_en[r][j]  <= 1'b0;
               key_off[r][j] <= '0;
            end
         end
      end else if (bus.i_rule_wren) begin
         if (region == 4'h0 && word == 4'h0) begin
            type_offset <= bus.i_rule_wdata[TYPE_OFFSET_WIDTH-1:0];
         end else if (region == 4'h1 && rule_addr_ok) begin
            if (word == 4'd0) rule_valid[rule_sel] <= bus.i_rule_wdata[0];
            if (word == 4'd1) rule_data[rule_sel]  <= bus.i_rule_wdata[TYPE_WIDTH-1:0];
            if (word == 4'd2) rule_mask[rule_sel]  <= bus.i_rule_wdata[TYPE_WIDTH-1:0];
            for (int j = 0; j < KEY_FIELD_NUM; j++) begin
               if (word == 4'(3 + j)) begin
                  key_en[rule_sel][j]  <= bus.i_rule_wdata[15];
                  key_off[rule_sel][j] <= bus.i_rule_wdata[KEY_OFFSET_WIDTH-1:0];
               end
            end
         end
      end
   end

`ifdef DEPARSER_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   logic        stats_clear;
   logic        out_xfer;

   assign stats_clear = bus.i_rule_wren && (region == 4'h2) && (word == 4'h0 || word == 4'h1);
   assign out_xfer    = bus.o_head_valid & bus.i_head_ready;

   // Saturating hit/miss counters; a clearing write beats a coincident count.
   always_ff @(posedge i_clk) begin
      if (i_rst || stats_clear) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (out_xfer) begin
         if (bus.o_hit) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
         end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

   // Config read mux over the current (pre-write) state.
   always_comb begin
      rd_mux = '0;
      case (region)
         4'h0: begin
            if (word == 4'h0) rd_mux = 32'(type_offset);
         end
         4'h1: begin
            if (rule_addr_ok) begin
               if (word == 4'd0) rd_mux = 32'(rule_valid[rule_sel]);
               if (word == 4'd1) rd_mux = 32'(rule_data[rule_sel]);
               if (word == 4'd2) rd_mux = 32'(rule_mask[rule_sel]);
               for (int j = 0; j < KEY_FIELD_NUM; j++) begin
                  if (word == 4'(3 + j)) begin
                     rd_mux = {16'd0, key_en[rule_sel][j], {(15-KEY_OFFSET_WIDTH){1'b0}},
                               key_off[rule_sel][j]};
                  end
               end
            end
         end
`ifdef DEPARSER_STATS_EN
         4'h2: begin
            if (word == 4'h0) rd_mux = hit_count;
            if (word == 4'h1) rd_mux = miss_count;
         end
`endif
         default: rd_mux = '0;
      endcase
   end

   // Registered read response, one cycle after the read strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_rule_rdata_valid <= 1'b0;
         bus.o_rule_rdata       <= '0;
      end else begin
         bus.o_rule_rdata_valid <= bus.i_rule_rden;
         bus.o_rule_rdata       <= bus.i_rule_rden ? rd_mux : '0;
      end
   end

   // Type word extraction from the incoming header, word 0 at the MSB.
   always_comb begin
      type_shamt = HEAD_WIDTH - TYPE_WIDTH - int'(type_offset) * TYPE_WIDTH;
      in_type    = TYPE_WIDTH'(bus.i_head >> type_shamt);
   end

   // Rule match; scanning downward leaves the lowest matching index.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      for (int r = RULE_NUM - 1; r >= 0; r--) begin
         if (rule_valid[r] && ((s1_type & rule_mask[r]) == (rule_data[r] & rule_mask[r]))) begin
            match_hit = 1'b1;
            match_idx = RIDX_W'(r);
         end
      end
   end

   // Key rewrite in field order so a later field wins on a shared offset.
   always_comb begin
      new_head = s1_head;
      if (match_hit) begin
         for (int j = 0; j < KEY_FIELD_NUM; j++) begin
            if (key_en[match_idx][j]) begin
               new_head = (new_head & ~(FIELD_TOP >> (int'(key_off[match_idx][j]) * W)))
                        | ({s1_keys[KEYS_W-1-j*W -: W], {(HEAD_WIDTH-W){1'b0}}}
                           >> (int'(key_off[match_idx][j]) * W));
            end
         end
      end
   end

   // Two-stage pipeline; both stages hold while the output is stalled.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid         <= 1'b0;
         s1_head          <= '0;
         s1_keys          <= '0;
         s1_type          <= '0;
         bus.o_head_valid <= 1'b0;
         bus.o_head       <= '0;
         bus.o_hit        <= 1'b0;
         bus.o_rule_idx   <= '0;
      end else if (!stall) begin
         s1_valid <= bus.i_head_valid;
         if (bus.i_head_valid) begin
            s1_head <= bus.i_head;
            s1_keys <= bus.i_meta[META_WIDTH-1 -: KEYS_W];
            s1_type <= in_type;
         end
         bus.o_head_valid <= s1_valid;
         if (s1_valid) begin
            bus.o_head     <= new_head;
            bus.o_hit      <= match_hit;
            bus.o_rule_idx <= match_idx;
         end
      end
   end
endmodule
